// File: rtl/genie_rr_merge.sv
`default_nettype none
// ============================================================================
// Module   : genie_rr_merge
// Function : N-input packet-aware round-robin merge onto one registered
//            valid/ready link; a started packet holds the grant until its EOP.
// Revision : 1.0 - initial release
// ============================================================================
module genie_rr_merge #(
    parameter int N     = 2,
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_valid,
    input  logic [N-1:0]       i_eop,
    output logic [N-1:0]       o_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_valid,
    output logic               o_eop,
    input  logic               i_ready
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] c_unlocked = 1'b0;
    localparam logic [0:0] c_locked   = 1'b1;

    logic [0:0]       r_state;
    logic [IDXW-1:0]  r_lock_idx;
    logic [IDXW-1:0]  r_last;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_eop;

    logic             w_space;
    logic [IDXW-1:0]  w_search;
    logic [IDXW-1:0]  w_sel;
    logic             w_accept;
    logic [WIDTH-1:0] w_acc_data;
    logic             w_acc_eop;

    assign w_space = !r_valid || i_ready;

    // Walk from the link farthest from last+1 down to the nearest, so the
    // nearest valid link (lowest rotational offset) is the one that sticks.
    always_comb begin
        int unsigned     k;
        logic [IDXW-1:0] k_idx;
        k        = (int'(r_last) + 1) % N;
        w_search = IDXW'(k);
        for (int i = N; i >= 1; i--) begin
            k     = (int'(r_last) + i) % N;
            k_idx = IDXW'(k);
            if (i_valid[k_idx]) begin
                w_search = k_idx;
            end
        end
    end

    assign w_sel = (r_state == c_locked) ? r_lock_idx : w_search;

    always_comb begin
        o_ready = '0;
        if (!i_reset && w_space) begin
            o_ready[w_sel] = 1'b1;
        end
    end

    assign w_accept   = i_valid[w_sel] && o_ready[w_sel];
    assign w_acc_data = i_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_acc_eop  = i_eop[w_sel];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= c_unlocked;
            r_lock_idx <= '0;
            r_last     <= IDXW'(N - 1);
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_eop      <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_acc_data;
            r_eop   <= w_acc_eop;
            r_valid <= 1'b1;
            r_last  <= w_sel;
            if (w_acc_eop) begin
                r_state <= c_unlocked;
            end else begin
                r_state    <= c_locked;
                r_lock_idx <= w_sel;
            end
        end else if (w_space) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_eop   = r_eop;

endmodule
`default_nettype wire

// File: tb/tb_genie_rr_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_genie_rr_merge
// Function : Directed self-checking bench for genie_rr_merge (N=2, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_genie_rr_merge;

    localparam int N     = 2;
    localparam int WIDTH = 8;

    logic               clk;
    logic               rst;
    logic [N*WIDTH-1:0] r_data;
    logic [N-1:0]       r_valid;
    logic [N-1:0]       r_eop;
    logic [N-1:0]       w_ready;
    logic [WIDTH-1:0]   w_odata;
    logic               w_ovalid;
    logic               w_oeop;
    logic               r_dready;

    int n_cmp;
    int n_bad;

    genie_rr_merge #(.N(N), .WIDTH(WIDTH)) u_dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (r_data),
        .i_valid (r_valid),
        .i_eop   (r_eop),
        .o_ready (w_ready),
        .o_data  (w_odata),
        .o_valid (w_ovalid),
        .o_eop   (w_oeop),
        .i_ready (r_dready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic e0,
                         input logic [7:0] d1, input logic e1);
        r_valid = v;
        r_data  = {d1, d0};
        r_eop   = {e1, e0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic e);
        check({tag, ".valid"}, 32'(w_ovalid), 32'(v));
        if (v) begin
            check({tag, ".data"}, 32'(w_odata), 32'(d));
            check({tag, ".eop"}, 32'(w_oeop), 32'(e));
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        r_dready = 1'b1;
        drive(2'b11, 8'h10, 1'b1, 8'h20, 1'b1);

        // Reset with all links valid
        tick();
        check("rst.valid", 32'(w_ovalid), 0);
        check("rst.ready", 32'(w_ready), 0);
        check("rst.data", 32'(w_odata), 0);
        check("rst.eop", 32'(w_oeop), 0);
        rst = 1'b0;
        #1;
        check("rst.first_ready", 32'(w_ready), 32'b01);

        // Single-beat packets alternate 0,1,0,1
        tick();
        check_out("alt0", 1'b1, 8'h10, 1'b1);
        check("alt0.ready", 32'(w_ready), 32'b10);
        tick();
        check_out("alt1", 1'b1, 8'h20, 1'b1);
        check("alt1.ready", 32'(w_ready), 32'b01);
        tick();
        check_out("alt2", 1'b1, 8'h10, 1'b1);
        tick();
        check_out("alt3", 1'b1, 8'h20, 1'b1);

        // 3-beat packet on link 0 vs single beat on link 1
        do_reset();
        drive(2'b11, 8'hA0, 1'b0, 8'hB0, 1'b1);
        #1;
        check("pkt.ready0", 32'(w_ready), 32'b01);
        tick();
        check_out("pkt.A0", 1'b1, 8'hA0, 1'b0);
        drive(2'b11, 8'hA1, 1'b0, 8'hB0, 1'b1);
        #1;
        check("pkt.lock1", 32'(w_ready), 32'b01);
        tick();
        check_out("pkt.A1", 1'b1, 8'hA1, 1'b0);
        drive(2'b11, 8'hA2, 1'b1, 8'hB0, 1'b1);
        #1;
        check("pkt.lock2", 32'(w_ready), 32'b01);
        tick();
        check_out("pkt.A2", 1'b1, 8'hA2, 1'b1);
        check("pkt.unlock", 32'(w_ready), 32'b10);
        drive(2'b10, 8'h00, 1'b0, 8'hB0, 1'b1);
        tick();
        check_out("pkt.B0", 1'b1, 8'hB0, 1'b1);
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check_out("pkt.idle", 1'b0, 8'h00, 1'b0);

        // Locked source idles; other link must wait
        do_reset();
        drive(2'b11, 8'hC0, 1'b0, 8'hD0, 1'b1);
        tick();
        check_out("gap.C0", 1'b1, 8'hC0, 1'b0);
        drive(2'b10, 8'h00, 1'b0, 8'hD0, 1'b1);
        #1;
        check("gap.ready", 32'(w_ready), 32'b01);
        tick();
        check_out("gap.bub0", 1'b0, 8'h00, 1'b0);
        check("gap.ready1", 32'(w_ready), 32'b01);
        tick();
        check_out("gap.bub1", 1'b0, 8'h00, 1'b0);
        drive(2'b11, 8'hC1, 1'b1, 8'hD0, 1'b1);
        tick();
        check_out("gap.C1", 1'b1, 8'hC1, 1'b1);
        check("gap.ready2", 32'(w_ready), 32'b10);
        tick();
        check_out("gap.D0", 1'b1, 8'hD0, 1'b1);

        // Downstream backpressure holds the output register
        do_reset();
        drive(2'b01, 8'hE0, 1'b1, 8'h00, 1'b0);
        tick();
        check_out("bp.E0", 1'b1, 8'hE0, 1'b1);
        drive(2'b01, 8'hE1, 1'b1, 8'h00, 1'b0);
        r_dready = 1'b0;
        #1;
        check("bp.ready", 32'(w_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp.hold", 1'b1, 8'hE0, 1'b1);
            check("bp.ready_hold", 32'(w_ready), 0);
        end
        r_dready = 1'b1;
        #1;
        check("bp.release", 32'(w_ready), 32'b01);
        tick();
        check_out("bp.E1", 1'b1, 8'hE1, 1'b1);
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check_out("bp.drain", 1'b0, 8'h00, 1'b0);

        // Reset mid-packet clears lock and held beat
        do_reset();
        drive(2'b11, 8'hF0, 1'b0, 8'h60, 1'b1);
        tick();
        check_out("mr.F0", 1'b1, 8'hF0, 1'b0);
        drive(2'b11, 8'hF1, 1'b0, 8'h60, 1'b1);
        tick();
        check_out("mr.F1", 1'b1, 8'hF1, 1'b0);
        rst = 1'b1;
        drive(2'b11, 8'hF2, 1'b0, 8'h60, 1'b1);
        #1;
        check("mr.ready_rst", 32'(w_ready), 0);
        tick();
        rst = 1'b0;
        drive(2'b10, 8'h00, 1'b0, 8'h60, 1'b1);
        #1;
        check_out("mr.cleared", 1'b0, 8'h00, 1'b0);
        check("mr.unlocked", 32'(w_ready), 32'b10);
        tick();
        check_out("mr.G0", 1'b1, 8'h60, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
